prog_loader: RTL
================

Name: prog_loader

Overview:
- Byte-stream instruction-memory loader: the writer side of the instruction memory that ControlUnit fetches from via PC.
- Receives a framed program over a valid/ready byte interface, assembles 16-bit instruction words and writes them into a dual-port instruction RAM at consecutive addresses from 0.
- Holds the processor in reset until a complete, checksum-verified image is loaded, then releases it.

Parameters:
- ADDR_W, 7, instruction address width (matches PC_Out); max image 2**ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Byte_In  input  8  incoming stream byte.
- Byte_Valid  input  1  Byte_In valid.
- Byte_Ready  output  1  loader can accept; a byte transfers on Byte_Valid && Byte_Ready at a rising edge.
- Start  input  1  one-cycle re-arm/abort pulse.
- IM_Addr  output  ADDR_W  instruction RAM write address.
- IM_Data  output  16  instruction RAM write data.
- IM_Wr  output  1  instruction RAM write strobe, one cycle per word.
- CPU_Hold  output  1  drives processor Reset (active-high); 1 = processor held.
- Words_Loaded  output  ADDR_W+1  words written in current frame.
- Done  output  1  image loaded and verified.
- Error  output  1  frame rejected.

Behaviour:
- Frame format: SYNC_BYTE, N (word count), then N words (high byte first, then low byte), then CHK = 8-bit mod-256 sum of all 2N data bytes. SYNC, N and CHK are not included in the sum.
- Reset (Reset=0, asynchronous) forces:
  - state IDLE
  - IM_Wr=0, IM_Addr=0, IM_Data=0, Words_Loaded=0
  - sum=0, CPU_Hold=1, Done=0, Error=0
  - Byte_Ready=0 (gated low while Reset asserted)
- All outputs are registered except Byte_Ready, which is a decode of state.
- States and transitions:
  - IDLE: Ready=1. Byte==SYNC_BYTE -> COUNT; any other byte is discarded.
  - COUNT: Ready=1. N==0 or N>2**ADDR_W -> ERROR. Otherwise latch N, clear sum and Words_Loaded -> HI.
  - HI: Ready=1. Latch high byte, add to sum -> LO.
  - LO: Ready=1. Latch low byte, add to sum, IM_Data <= {hi,lo} -> WRITE.
  - WRITE: Ready=0, IM_Wr=1 for exactly this cycle with IM_Addr=Words_Loaded[ADDR_W-1:0]. On exit Words_Loaded increments. If Words_Loaded+1==N -> CHECK, else -> HI.
  - CHECK: Ready=1. Byte==sum -> DONE, else -> ERROR.
  - DONE: Ready=0, Done=1, CPU_Hold=0 (registered; deasserts on the cycle after CHECK accept).
  - ERROR: Ready=1, all bytes drained and discarded, Error=1, CPU_Hold=1.
- Start (any state) -> IDLE next cycle:
  - clears Done, Error, Words_Loaded; sets CPU_Hold=1.
  - Start takes priority over a simultaneous byte transfer; that byte is dropped.
  - A mid-frame abort leaves already-written RAM words unchanged.
- Latency: the IM_Wr pulse is the cycle after the low-byte transfer. Minimum 3 cycles per word.
- Byte_Valid held during WRITE or DONE is not consumed; the source must hold the byte until Ready.
- Write-address wrap cannot occur because N is bounded. With N=2**ADDR_W the last write is at address 2**ADDR_W-1.
- Mid-frame Reset: returns to the reset values above; the partial image is not valid and CPU_Hold stays 1.

Decomposition:
- Package prog_loader_pkg: state enum (IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERROR) and the SYNC_BYTE default constant.
- Single module; no sub-module needed. Checksum accumulator and word assembler live inline.

Test Plan:
- Load stream A5 09 21 B1 22 A2 23 C3 27 E4 41 25 35 36 46 4A 1A 6A 50 00 BC -> 9 IM_Wr pulses at addresses 0..8 with data 21B1, 22A2, 23C3, 27E4, 4125, 3536, 464A, 1A6A, 5000; Words_Loaded=9; Done=1; CPU_Hold=0 one cycle after BC accepted.
- Same stream with CHK=BD -> all 9 writes occur, then Error=1, Done=0, CPU_Hold=1; following bytes accepted and discarded.
- Counts: 00 -> ERROR after count byte, no IM_Wr; 81 -> ERROR; 80 -> accepted, last write at address 7F.
- Bytes 00 FF 5A before A5, then a valid 1-word frame -> leading bytes ignored, single write at address 0.
- Byte_Valid held continuously plus random Valid gaps -> Byte_Ready=0 in every WRITE cycle, no byte lost or duplicated, identical RAM contents to the first scenario.
- Abort paths:
  - Start pulse after the 3rd word -> IDLE, Words_Loaded=0, CPU_Hold=1; a new frame loads correctly.
  - Reset asserted mid-word -> all outputs at reset values immediately (asynchronously).

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    HI,
    LO,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // The loader accepts bytes in every state except the RAM write slot and after success.
  function automatic logic state_ready(input state_t s);
    return !(s == WRITE || s == DONE);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Receives a framed program byte stream, writes 16-bit words to instruction RAM,
// and holds the CPU in reset until a checksum-verified image is present.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = 7,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        Byte_In,
  input  logic              Byte_Valid,
  output logic              Byte_Ready,
  input  logic              Start,
  output logic [ADDR_W-1:0] IM_Addr,
  output logic [15:0]       IM_Data,
  output logic              IM_Wr,
  output logic              CPU_Hold,
  output logic [ADDR_W:0]   Words_Loaded,
  output logic              Done,
  output logic              Error
);

  localparam int MAX_WORDS = 1 << ADDR_W;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [15:0]       data_reg, data_next;
  logic              wr_reg, wr_next;
  logic [ADDR_W:0]   words_reg, words_next;
  logic [ADDR_W:0]   n_reg, n_next;
  logic [7:0]        sum_reg, sum_next;
  logic [7:0]        hi_reg, hi_next;
  logic              hold_reg, hold_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              ready;
  logic              accept;

  assign ready      = state_ready(state_reg);
  assign accept     = Byte_Valid && ready;
  assign Byte_Ready = ready && Reset;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    wr_next    = 1'b0;
    words_next = words_reg;
    n_next     = n_reg;
    sum_next   = sum_reg;
    hi_next    = hi_reg;
    hold_next  = hold_reg;
    done_next  = done_reg;
    err_next   = err_reg;

    // Start wins over any byte offered in the same cycle; that byte is dropped.
    if (Start) begin
      state_next = IDLE;
      done_next  = 1'b0;
      err_next   = 1'b0;
      words_next = '0;
      hold_next  = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept && Byte_In == SYNC_BYTE) state_next = COUNT;
        end
        COUNT: begin
          if (accept) begin
            if (Byte_In == 8'd0 || int'(Byte_In) > MAX_WORDS) begin
              state_next = ERROR;
              err_next   = 1'b1;
            end else begin
              n_next     = (ADDR_W+1)'(Byte_In);
              sum_next   = 8'd0;
              words_next = '0;
              state_next = HI;
            end
          end
        end
        HI: begin
          if (accept) begin
            hi_next    = Byte_In;
            sum_next   = sum_reg + Byte_In;
            state_next = LO;
          end
        end
        LO: begin
          if (accept) begin
            sum_next   = sum_reg + Byte_In;
            data_next  = {hi_reg, Byte_In};
            addr_next  = words_reg[ADDR_W-1:0];
            wr_next    = 1'b1;
            state_next = WRITE;
          end
        end
        WRITE: begin
          words_next = words_reg + 1'b1;
          state_next = (words_next == n_reg) ? CHECK : HI;
        end
        CHECK: begin
          if (accept) begin
            if (Byte_In == sum_reg) begin
              state_next = DONE;
              done_next  = 1'b1;
              hold_next  = 1'b0;
            end else begin
              state_next = ERROR;
              err_next   = 1'b1;
            end
          end
        end
        DONE:    state_next = DONE;
        ERROR:   state_next = ERROR;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
      wr_reg    <= 1'b0;
      words_reg <= '0;
      n_reg     <= '0;
      sum_reg   <= '0;
      hi_reg    <= '0;
      hold_reg  <= 1'b1;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      wr_reg    <= wr_next;
      words_reg <= words_next;
      n_reg     <= n_next;
      sum_reg   <= sum_next;
      hi_reg    <= hi_next;
      hold_reg  <= hold_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign IM_Addr      = addr_reg;
  assign IM_Data      = data_reg;
  assign IM_Wr        = wr_reg;
  assign Words_Loaded = words_reg;
  assign CPU_Hold     = hold_reg;
  assign Done         = done_reg;
  assign Error        = err_reg;

endmodule
